dispense_sequencer: RTL and testbench

Sits between the menu selector and the balance controller of the food machine, and owns the four product outputs. Accepts one order at a time from the menu: item code plus price. Checks the price against the current balance, requests a debit from the balance controller, then drives exactly one product output for a timed pulse, followed by a cooldown. Reports the order outcome to the menu and front panel.

---
 rtl/food_machine_pkg.sv | 42 ++++
 rtl/dispense_timer.sv | 35 +++
 rtl/dispense_sequencer.sv | 177 +++++++++++++++++
 tb/tb_dispense_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/food_machine_pkg.sv
// Shared definitions for the food machine: item/status codes, sequencer states,
// credit and timer widths, and the item-to-output decode.
package food_machine_pkg;

    localparam int unsigned CREDIT_W = 6;
    localparam int unsigned ITEM_W   = 2;
    localparam int unsigned TIMER_W  = 26;

    localparam logic [ITEM_W-1:0] ITEM_PIZZA   = 2'd0;
    localparam logic [ITEM_W-1:0] ITEM_BURGUER = 2'd1;
    localparam logic [ITEM_W-1:0] ITEM_TORTA   = 2'd2;
    localparam logic [ITEM_W-1:0] ITEM_SODA    = 2'd3;

    localparam logic [1:0] ST_OK         = 2'd0;
    localparam logic [1:0] ST_INSUFF     = 2'd1;
    localparam logic [1:0] ST_SOLDOUT    = 2'd2;
    localparam logic [1:0] ST_DEBIT_FAIL = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_DEBIT,
        S_DISPENSE,
        S_COOLDOWN,
        S_REJECT
    } seq_state_e;

    // Bit order matches {soda, torta, burguer, pizza}.
    function automatic logic [3:0] item_onehot(input logic [ITEM_W-1:0] item);
        logic [3:0] oh;
        oh = '0;
        unique case (item)
            ITEM_PIZZA:   oh = 4'b0001;
            ITEM_BURGUER: oh = 4'b0010;
            ITEM_TORTA:   oh = 4'b0100;
            ITEM_SODA:    oh = 4'b1000;
            default:      oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/dispense_timer.sv
// Loadable down-counter shared by the debit timeout, dispense and cooldown phases.
// Stops at 1 (no wrap); done is high while the count is 1.
module dispense_timer
    import food_machine_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic [TIMER_W-1:0] load_val_i,
    output logic               done_o
);

    logic [TIMER_W-1:0] cnt_q;
    logic [TIMER_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q > TIMER_W'(1)) begin
            cnt_d = cnt_q - TIMER_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == TIMER_W'(1));

endmodule

// File: rtl/dispense_sequencer.sv
// Order sequencer: price check, debit handshake, timed one-hot product pulse, cooldown.
// Optional per-item stock counting is enabled by defining DISPENSE_INVENTORY_EN.
module dispense_sequencer
    import food_machine_pkg::*;
#(
    parameter int unsigned DISPENSE_CYCLES = 50000000,
    parameter int unsigned COOLDOWN_CYCLES = 25000000,
    parameter int unsigned DEBIT_TIMEOUT   = 16
`ifdef DISPENSE_INVENTORY_EN
    ,
    parameter int unsigned STOCK_INIT      = 7
`endif
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    input  logic [ITEM_W-1:0]   req_item,
    input  logic [CREDIT_W-1:0] req_price,
    output logic                req_ready,
    input  logic [CREDIT_W-1:0] saldo_in,
    output logic                debit_valid,
    output logic [CREDIT_W-1:0] debit_amount,
    input  logic                debit_ack,
    output logic                pizza,
    output logic                burguer,
    output logic                torta,
    output logic                soda,
    output logic                busy,
    output logic                status_valid,
    output logic [1:0]          status
);

    seq_state_e          state_q, state_d;
    logic [ITEM_W-1:0]   item_q;
    logic [CREDIT_W-1:0] price_q;
    logic [1:0]          code_q, code_d;
    logic [1:0]          status_q;
    logic [3:0]          prod_q, prod_d;
    logic                soldout;
    logic                insuff;
    logic                tmr_load;
    logic [TIMER_W-1:0]  tmr_val;
    logic                tmr_done;

    assign insuff = (saldo_in < price_q);

`ifdef DISPENSE_INVENTORY_EN
    logic [3:0][3:0] stock_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            stock_q <= {4{4'(STOCK_INIT)}};
        end else if (state_q == S_DEBIT && state_d == S_DISPENSE && stock_q[item_q] != 4'd0) begin
            stock_q[item_q] <= stock_q[item_q] - 4'd1;
        end
    end

    assign soldout = (stock_q[item_q] == 4'd0);
`else
    assign soldout = 1'b0;
`endif

    dispense_timer u_timer (
        .clk_i      (clock),
        .rst_i      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            item_q   <= '0;
            price_q  <= '0;
            code_q   <= ST_OK;
            status_q <= ST_OK;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            status_q <= status;
            prod_q   <= prod_d;
            if (req_valid && req_ready) begin
                item_q  <= req_item;
                price_q <= req_price;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (soldout || insuff) begin
                    state_d = S_REJECT;
                    code_d  = soldout ? ST_SOLDOUT : ST_INSUFF;
                end else begin
                    state_d = S_DEBIT;
                end
            end
            S_DEBIT: begin
                // An ack on the last timeout cycle still wins over the abort.
                if (debit_ack) begin
                    state_d = S_DISPENSE;
                end else if (tmr_done) begin
                    state_d = S_REJECT;
                    code_d  = ST_DEBIT_FAIL;
                end
            end
            S_DISPENSE: begin
                if (tmr_done) state_d = S_COOLDOWN;
            end
            S_COOLDOWN: begin
                if (tmr_done) state_d = S_IDLE;
            end
            S_REJECT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        if (state_d != state_q) begin
            unique case (state_d)
                S_DEBIT: begin
                    tmr_load = 1'b1;
                    tmr_val  = TIMER_W'(DEBIT_TIMEOUT);
                end
                S_DISPENSE: begin
                    tmr_load = 1'b1;
                    tmr_val  = TIMER_W'(DISPENSE_CYCLES);
                end
                S_COOLDOWN: begin
                    tmr_load = 1'b1;
                    tmr_val  = TIMER_W'(COOLDOWN_CYCLES);
                end
                default: begin
                    tmr_load = 1'b0;
                end
            endcase
        end
    end

    // Product outputs are registered from the next state so they track DISPENSE exactly.
    always_comb begin
        prod_d       = (state_d == S_DISPENSE) ? item_onehot(item_q) : '0;
        req_ready    = (state_q == S_IDLE);
        busy         = (state_q != S_IDLE);
        debit_valid  = (state_q == S_DEBIT);
        debit_amount = (state_q == S_DEBIT) ? price_q : '0;
        status_valid = 1'b0;
        status       = status_q;
        if (state_q == S_REJECT) begin
            status_valid = 1'b1;
            status       = code_q;
        end else if (state_q == S_DISPENSE && tmr_done) begin
            status_valid = 1'b1;
            status       = ST_OK;
        end
    end

    assign pizza   = prod_q[0];
    assign burguer = prod_q[1];
    assign torta   = prod_q[2];
    assign soda    = prod_q[3];

endmodule

// File: tb/tb_dispense_sequencer.sv
// Directed bench for dispense_sequencer with short dispense/cooldown/timeout settings.
module tb_dispense_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic [1:0] req_item = 2'd0;
    logic [5:0] req_price = 6'd0;
    logic       req_ready;
    logic [5:0] saldo_in = 6'd0;
    logic       debit_valid;
    logic [5:0] debit_amount;
    logic       debit_ack = 1'b0;
    logic       pizza, burguer, torta, soda;
    logic       busy, status_valid;
    logic [1:0] status;
    logic [7:0] obs;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clock = ~clock;

`ifdef DISPENSE_INVENTORY_EN
    dispense_sequencer #(
        .DISPENSE_CYCLES (4),
        .COOLDOWN_CYCLES (3),
        .DEBIT_TIMEOUT   (5),
        .STOCK_INIT      (2)
    ) dut (
`else
    dispense_sequencer #(
        .DISPENSE_CYCLES (4),
        .COOLDOWN_CYCLES (3),
        .DEBIT_TIMEOUT   (5)
    ) dut (
`endif
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_item     (req_item),
        .req_price    (req_price),
        .req_ready    (req_ready),
        .saldo_in     (saldo_in),
        .debit_valid  (debit_valid),
        .debit_amount (debit_amount),
        .debit_ack    (debit_ack),
        .pizza        (pizza),
        .burguer      (burguer),
        .torta        (torta),
        .soda         (soda),
        .busy         (busy),
        .status_valid (status_valid),
        .status       (status)
    );

    // {req_ready, busy, debit_valid, status_valid, soda, torta, burguer, pizza}
    assign obs = {req_ready, busy, debit_valid, status_valid, soda, torta, burguer, pizza};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Full successful order; d = cycles debit_valid is high before the ack cycle.
    task automatic order_ok(input logic [1:0] item, input logic [5:0] price, input logic [5:0] saldo,
                            input int unsigned d, input bit hold, input logic [1:0] other,
                            input string tag);
        logic [3:0] oh;
        logic [7:0] exp;
        oh = 4'b0001 << item;
        saldo_in  = saldo;
        req_valid = 1'b1;
        req_item  = item;
        req_price = price;
        chk({tag, " idle"}, obs, 8'b1000_0000);
        for (int unsigned t = 1; t <= 10 + d; t++) begin
            @(negedge clock);
            if (hold && t <= 8 + d) begin
                req_valid = 1'b1;
                req_item  = other;
                req_price = 6'd1;
            end else begin
                req_valid = 1'b0;
            end
            debit_ack = (t == 2 + d);
            if (t == 1)           exp = 8'b0100_0000;
            else if (t <= 2 + d)  exp = 8'b0110_0000;
            else if (t <= 5 + d)  exp = {4'b0100, oh};
            else if (t == 6 + d)  exp = {4'b0101, oh};
            else if (t <= 9 + d)  exp = 8'b0100_0000;
            else                  exp = 8'b1000_0000;
            chk($sformatf("%s t%0d", tag, t), obs, exp);
            if (t == 2 + d) chk($sformatf("%s amount", tag), debit_amount, price);
            if (t == 6 + d) chk($sformatf("%s status", tag), status, 2'd0);
        end
        debit_ack = 1'b0;
    endtask

    task automatic order_reject(input logic [1:0] item, input logic [5:0] price, input logic [5:0] saldo,
                                input logic [1:0] code, input string tag);
        saldo_in  = saldo;
        req_valid = 1'b1;
        req_item  = item;
        req_price = price;
        chk({tag, " idle"}, obs, 8'b1000_0000);
        @(negedge clock);
        req_valid = 1'b0;
        chk({tag, " check"}, obs, 8'b0100_0000);
        @(negedge clock);
        chk({tag, " pulse"}, obs, 8'b0101_0000);
        chk({tag, " code"}, status, code);
        @(negedge clock);
        chk({tag, " ready"}, obs, 8'b1000_0000);
        chk({tag, " hold"}, status, code);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("reset obs", obs, 8'b1000_0000);
        chk("reset status", status, 2'd0);
        chk("reset amount", debit_amount, 6'd0);

        order_ok(2'd0, 6'd12, 6'd20, 2, 1'b0, 2'd0, "pizza_ok");
        order_reject(2'd3, 6'd6, 6'd5, 2'd1, "soda_insuff");
        order_ok(2'd0, 6'd5, 6'd30, 1, 1'b1, 2'd3, "hold_busy");

        // Debit never acknowledged; late ack in REJECT/IDLE must be ignored.
        saldo_in  = 6'd10;
        req_valid = 1'b1;
        req_item  = 2'd2;
        req_price = 6'd10;
        for (int unsigned t = 1; t <= 9; t++) begin
            @(negedge clock);
            req_valid = 1'b0;
            debit_ack = (t == 7 || t == 8);
            if (t == 1)      chk($sformatf("timeout t%0d", t), obs, 8'b0100_0000);
            else if (t <= 6) chk($sformatf("timeout t%0d", t), obs, 8'b0110_0000);
            else if (t == 7) chk($sformatf("timeout t%0d", t), obs, 8'b0101_0000);
            else             chk($sformatf("timeout t%0d", t), obs, 8'b1000_0000);
            if (t == 6) chk("timeout amount", debit_amount, 6'd10);
            if (t == 7) chk("timeout code", status, 2'd3);
        end
        debit_ack = 1'b0;

        // Reset on the second burguer dispense cycle.
        saldo_in  = 6'd20;
        req_valid = 1'b1;
        req_item  = 2'd1;
        req_price = 6'd3;
        for (int unsigned t = 1; t <= 4; t++) begin
            @(negedge clock);
            req_valid = 1'b0;
            debit_ack = (t == 2);
        end
        debit_ack = 1'b0;
        chk("rst burguer on", obs, 8'b0100_0010);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("rst obs", obs, 8'b1000_0000);
        chk("rst status", status, 2'd0);
        chk("rst amount", debit_amount, 6'd0);

        order_ok(2'd3, 6'd0, 6'd0, 0, 1'b0, 2'd0, "price0");

`ifdef DISPENSE_INVENTORY_EN
        pulse_reset();
        order_ok(2'd0, 6'd1, 6'd63, 0, 1'b0, 2'd0, "stock1");
        order_ok(2'd0, 6'd1, 6'd63, 0, 1'b0, 2'd0, "stock2");
        order_reject(2'd0, 6'd1, 6'd0, 2'd2, "soldout");
        order_ok(2'd1, 6'd1, 6'd63, 0, 1'b0, 2'd0, "other_item");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
